// File: rtl/decoder_onehot_pipe_pkg.sv
// Shared types and the pure decode function for decoder_onehot_pipe.
// Mode encoding, buffer-state encoding and a width-agnostic decoder live here.
package dec_pkg;

    localparam int DEC_MAX_W = 1024;

    typedef enum logic [1:0] {
        DEC_ONEHOT   = 2'b00,
        DEC_THERM    = 2'b01,
        DEC_ONEHOT_N = 2'b10,
        DEC_RSVD     = 2'b11
    } dec_mode_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } buf_state_t;

    // Returns the widest possible vector; callers truncate to their own OUT_W.
    function automatic logic [DEC_MAX_W-1:0] dec_decode(
        input logic [9:0] code,
        input logic [1:0] mode,
        input int         out_w
    );
        logic [DEC_MAX_W-1:0] vec;
        vec = '0;
        for (int k = 0; k < DEC_MAX_W; k++) begin
            case (mode)
                DEC_ONEHOT:   vec[k] = (k == int'(code));
                DEC_THERM:    vec[k] = (k <= int'(code));
                DEC_ONEHOT_N: vec[k] = (k != int'(code));
                default:      vec[k] = 1'b0;
            endcase
        end
        if (int'(code) >= out_w) begin
            vec = (mode == DEC_ONEHOT_N) ? '1 : '0;
        end
        return vec;
    endfunction

endpackage

// File: rtl/decoder_onehot_pipe_if.sv
// Producer/consumer bundle for decoder_onehot_pipe; the block sits on the slave modport.
interface decoder_onehot_pipe_if #(
    parameter int IN_W  = 6,
    parameter int OUT_W = 64,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_vec;
    logic [IN_W-1:0]  out_code;
    logic [CNT_W-1:0] xfer_cnt;
    logic             err_clr;
    logic             err_oor;

    modport master (
        output in_valid, in_code, in_mode, out_ready, err_clr,
        input  in_ready, out_valid, out_vec, out_code, xfer_cnt, err_oor
    );

    modport slave (
        input  in_valid, in_code, in_mode, out_ready, err_clr,
        output in_ready, out_valid, out_vec, out_code, xfer_cnt, err_oor
    );
endinterface

// File: rtl/dec_skid_buf.sv
// Generic two-entry valid/ready skid buffer: output register plus one skid register.
// in_ready is registered, so out_ready never reaches in_ready combinationally.
module dec_skid_buf
    import dec_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t   state_reg;
    logic [W-1:0] out_data_reg;
    logic [W-1:0] skid_reg;
    logic         in_ready_reg;
    logic         out_valid_reg;
    logic         in_xfer;
    logic         out_xfer;

    assign in_xfer   = in_valid & in_ready_reg;
    assign out_xfer  = out_valid_reg & out_ready;
    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            skid_reg      <= '0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        out_data_reg  <= in_data;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        skid_reg     <= in_data;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_FULL;
                    end else if (in_xfer && out_xfer) begin
                        out_data_reg <= in_data;
                    end else if (out_xfer) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Oldest entry leaves; the skid entry becomes the head.
                    if (out_xfer) begin
                        out_data_reg <= skid_reg;
                        in_ready_reg <= 1'b1;
                        state_reg    <= ST_ONE;
                    end
                end
                default: begin
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    state_reg     <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/decoder_onehot_pipe.sv
// Pipelined binary-to-vector decoder with skid-buffered output and transfer counter.
// Define DEC_OOR_ERR_EN to enable the sticky out-of-range flag err_oor.
module decoder_onehot_pipe
    import dec_pkg::*;
#(
    parameter int IN_W  = 6,
    parameter int OUT_W = 64,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decoder_onehot_pipe_if.slave  bus
);

    localparam int PAY_W = OUT_W + IN_W;

    logic [OUT_W-1:0] dec_vec;
    logic [PAY_W-1:0] in_payload;
    logic [PAY_W-1:0] out_payload;
    logic             buf_in_ready;
    logic             buf_out_valid;
    logic [CNT_W-1:0] cnt_reg;

    assign dec_vec    = OUT_W'(dec_decode(10'(bus.in_code), bus.in_mode, OUT_W));
    assign in_payload = {dec_vec, bus.in_code};

    dec_skid_buf #(
        .W (PAY_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (buf_in_ready),
        .in_data   (in_payload),
        .out_valid (buf_out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_payload)
    );

    assign bus.in_ready  = buf_in_ready;
    assign bus.out_valid = buf_out_valid;
    assign bus.out_vec   = out_payload[PAY_W-1:IN_W];
    assign bus.out_code  = out_payload[IN_W-1:0];
    assign bus.xfer_cnt  = cnt_reg;

    // Natural wrap at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (buf_out_valid && bus.out_ready) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

`ifdef DEC_OOR_ERR_EN
    logic err_reg;
    logic code_oor;

    assign code_oor = (32'(bus.in_code) >= 32'(OUT_W)) || (bus.in_mode == DEC_RSVD);

    // A new error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (bus.in_valid && buf_in_ready && code_oor) begin
            err_reg <= 1'b1;
        end else if (bus.err_clr) begin
            err_reg <= 1'b0;
        end
    end

    assign bus.err_oor = err_reg;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.err_oor    = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// Self-checking bench for decoder_onehot_pipe: instance A (6/64/16) and instance B (4/10/4).
// Table vectors, directed multi-cycle sequences and a randomized scoreboard run.
module tb_decoder_onehot_pipe;

    localparam int A_IN_W = 6, A_OUT_W = 64, A_CNT_W = 16;
    localparam int B_IN_W = 4, B_OUT_W = 10, B_CNT_W = 4;
`ifdef DEC_OOR_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decoder_onehot_pipe_if #(.IN_W(A_IN_W), .OUT_W(A_OUT_W), .CNT_W(A_CNT_W)) a_if ();
    decoder_onehot_pipe_if #(.IN_W(B_IN_W), .OUT_W(B_OUT_W), .CNT_W(B_CNT_W)) b_if ();

    decoder_onehot_pipe #(.IN_W(A_IN_W), .OUT_W(A_OUT_W), .CNT_W(A_CNT_W)) u_a (
        .clk (clk), .rst_n (rst_n), .bus (a_if.slave)
    );
    decoder_onehot_pipe #(.IN_W(B_IN_W), .OUT_W(B_OUT_W), .CNT_W(B_CNT_W)) u_b (
        .clk (clk), .rst_n (rst_n), .bus (b_if.slave)
    );

    // Per-instance drive and observe arrays: index 0 = A, 1 = B.
    logic         d_valid [2];
    logic [9:0]   d_code  [2];
    logic [1:0]   d_mode  [2];
    logic         d_ordy  [2];
    logic         d_clr   [2];
    logic         o_irdy  [2];
    logic         o_ovld  [2];
    logic         o_err   [2];
    logic [127:0] o_vec   [2];
    logic [31:0]  o_code  [2];
    logic [31:0]  o_cnt   [2];

    assign a_if.in_valid  = d_valid[0];
    assign a_if.in_code   = d_code[0][A_IN_W-1:0];
    assign a_if.in_mode   = d_mode[0];
    assign a_if.out_ready = d_ordy[0];
    assign a_if.err_clr   = d_clr[0];
    assign b_if.in_valid  = d_valid[1];
    assign b_if.in_code   = d_code[1][B_IN_W-1:0];
    assign b_if.in_mode   = d_mode[1];
    assign b_if.out_ready = d_ordy[1];
    assign b_if.err_clr   = d_clr[1];

    assign o_irdy[0] = a_if.in_ready;
    assign o_ovld[0] = a_if.out_valid;
    assign o_err[0]  = a_if.err_oor;
    assign o_vec[0]  = 128'(a_if.out_vec);
    assign o_code[0] = 32'(a_if.out_code);
    assign o_cnt[0]  = 32'(a_if.xfer_cnt);
    assign o_irdy[1] = b_if.in_ready;
    assign o_ovld[1] = b_if.out_valid;
    assign o_err[1]  = b_if.err_oor;
    assign o_vec[1]  = 128'(b_if.out_vec);
    assign o_code[1] = 32'(b_if.out_code);
    assign o_cnt[1]  = 32'(b_if.xfer_cnt);

    typedef struct {
        logic [9:0]   code;
        logic [1:0]   mode;
        logic [127:0] vec;
    } vec_t;

    typedef struct {
        logic [127:0] vec;
        logic [9:0]   code;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    logic err_exp [2];
    int   cnt_exp [2];
    vec_t tbl [12];
    exp_t q [$];

    function automatic int out_w_of(int i);
        return (i == 0) ? A_OUT_W : B_OUT_W;
    endfunction

    function automatic int cnt_mod_of(int i);
        return (i == 0) ? (1 << A_CNT_W) : (1 << B_CNT_W);
    endfunction

    // Reference decode from the mode rules, using shifts and subtraction.
    function automatic logic [127:0] ref_vec(int code, int mode, int out_w);
        logic [127:0] all_ones;
        all_ones = (128'd1 << out_w) - 128'd1;
        if (code >= out_w) return (mode == 2) ? all_ones : 128'd0;
        case (mode)
            0:       return 128'd1 << code;
            1:       return (128'd1 << (code + 1)) - 128'd1;
            2:       return all_ones & ~(128'd1 << code);
            default: return 128'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            d_valid[i] = 1'b0; d_code[i] = '0; d_mode[i] = '0;
            d_ordy[i]  = 1'b0; d_clr[i]  = 1'b0;
            err_exp[i] = 1'b0; cnt_exp[i] = 0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{10'd3,  2'd1, 128'h00F};
        tbl[1]  = '{10'd3,  2'd2, 128'h3F7};
        tbl[2]  = '{10'd3,  2'd3, 128'h000};
        tbl[3]  = '{10'd3,  2'd0, 128'h008};
        tbl[4]  = '{10'd12, 2'd0, 128'h000};
        tbl[5]  = '{10'd12, 2'd2, 128'h3FF};
        tbl[6]  = '{10'd12, 2'd1, 128'h000};
        tbl[7]  = '{10'd9,  2'd1, 128'h3FF};
        tbl[8]  = '{10'd0,  2'd2, 128'h3FE};
        tbl[9]  = '{10'd15, 2'd3, 128'h000};
        tbl[10] = '{10'd9,  2'd0, 128'h200};
        tbl[11] = '{10'd0,  2'd1, 128'h001};

        // Reset values on both instances.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            check("reset in_ready",  o_irdy[i], 1);
            check("reset out_valid", o_ovld[i], 0);
            check("reset out_vec",   o_vec[i],  0);
            check("reset out_code",  o_code[i], 0);
            check("reset xfer_cnt",  o_cnt[i],  0);
            check("reset err_oor",   o_err[i],  0);
        end

        // Single transfer on A: code 5 one-hot.
        d_valid[0] = 1'b1; d_code[0] = 10'd5; d_mode[0] = 2'd0; d_ordy[0] = 1'b1;
        step();
        check("single out_valid", o_ovld[0], 1);
        check("single out_vec",   o_vec[0],  128'h20);
        check("single out_code",  o_code[0], 5);
        d_valid[0] = 1'b0;
        step();
        check("single xfer_cnt",  o_cnt[0],  1);
        check("single drained",   o_ovld[0], 0);
        $display("single: code=5 mode=0 out_vec=0x20 transferred");

        // Table-driven vectors on B (OUT_W=10), one code at a time.
        d_ordy[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            d_valid[1] = 1'b1; d_code[1] = tbl[k].code; d_mode[1] = tbl[k].mode;
            step();
            if (ERR_EN && (tbl[k].code >= 10'd10 || tbl[k].mode == 2'd3)) err_exp[1] = 1'b1;
            check("table out_valid", o_ovld[1], 1);
            check("table out_vec",   o_vec[1],  tbl[k].vec);
            check("table out_code",  o_code[1], 128'(tbl[k].code));
            check("table err_oor",   o_err[1],  err_exp[1]);
            $display("vector %0d: code=%0d mode=%0d out_vec=0x%0h", k, tbl[k].code, tbl[k].mode, o_vec[1]);
            d_valid[1] = 1'b0;
            step();
        end

        // Clear together with a new error keeps the flag; a lone clear drops it.
        d_valid[1] = 1'b1; d_code[1] = 10'd12; d_mode[1] = 2'd0; d_clr[1] = 1'b1;
        step();
        check("clr+err err_oor", o_err[1], ERR_EN ? 1 : 0);
        d_valid[1] = 1'b0;
        step();
        check("clr err_oor",     o_err[1], 0);
        check("table xfer_cnt",  o_cnt[1], 13);
        d_clr[1] = 1'b0;
        $display("err_clr sequence done");

        // Backpressure on A: 1 and 2 accepted, 3 held, then drained in order.
        do_reset();
        d_ordy[0] = 1'b0; d_valid[0] = 1'b1; d_mode[0] = 2'd0; d_code[0] = 10'd1;
        step();
        check("bp in_ready after 1", o_irdy[0], 1);
        d_code[0] = 10'd2;
        step();
        check("bp in_ready full",    o_irdy[0], 0);
        d_code[0] = 10'd3;
        step();
        step();
        check("bp held in_ready",    o_irdy[0], 0);
        check("bp held out_vec",     o_vec[0],  128'h02);
        d_ordy[0] = 1'b1;
        step();
        check("bp out 2 valid",      o_ovld[0], 1);
        check("bp out 2 vec",        o_vec[0],  128'h04);
        step();
        d_valid[0] = 1'b0;
        check("bp out 3 valid",      o_ovld[0], 1);
        check("bp out 3 vec",        o_vec[0],  128'h08);
        step();
        check("bp drained",          o_ovld[0], 0);
        check("bp xfer_cnt",         o_cnt[0],  3);
        $display("backpressure: outputs 0x02 0x04 0x08 delivered");

        // Counter wrap on B (CNT_W=4): 17 back-to-back transfers.
        do_reset();
        d_ordy[1] = 1'b1; d_valid[1] = 1'b1; d_mode[1] = 2'd0;
        for (int c = 0; c < 17; c++) begin
            d_code[1] = 10'(c % 10);
            step();
            if (c == 15) check("wrap cnt before", o_cnt[1], 15);
        end
        d_valid[1] = 1'b0;
        step();
        check("wrap xfer_cnt", o_cnt[1], 1);
        check("wrap drained",  o_ovld[1], 0);
        $display("wrap: 17 transfers, xfer_cnt=%0d", o_cnt[1]);

        // Reset while A is FULL.
        do_reset();
        d_valid[0] = 1'b1; d_code[0] = 10'd7;
        step();
        d_code[0] = 10'd8;
        step();
        check("mid full in_ready", o_irdy[0], 0);
        d_valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", o_ovld[0], 0);
        check("mid rst in_ready",  o_irdy[0], 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("mid post out_valid", o_ovld[0], 0);
        check("mid post xfer_cnt",  o_cnt[0],  0);
        d_valid[0] = 1'b1; d_code[0] = 10'd9; d_ordy[0] = 1'b1;
        step();
        check("mid new out_vec",  o_vec[0],  128'h200);
        check("mid new out_code", o_code[0], 9);
        d_valid[0] = 1'b0;
        step();
        check("mid new drained",  o_ovld[0], 0);
        check("mid new xfer_cnt", o_cnt[0],  1);
        $display("reset mid-stream: buffer flushed, new code 9 delivered");

        // Randomized traffic against a queue-based scoreboard, per instance.
        for (int i = 0; i < 2; i++) begin
            do_reset();
            q.delete();
            for (int c = 0; c < 600; c++) begin
                logic ix, ox, bad;
                exp_t e;
                d_valid[i] = ($urandom_range(0, 3) != 0);
                d_code[i]  = 10'($urandom_range(0, (i == 0) ? 63 : 15));
                d_mode[i]  = 2'($urandom_range(0, 3));
                d_ordy[i]  = ($urandom_range(0, 3) != 0);
                d_clr[i]   = ($urandom_range(0, 15) == 0);
                @(negedge clk);
                check("rnd in_ready",  o_irdy[i], (q.size() < 2) ? 1 : 0);
                check("rnd out_valid", o_ovld[i], (q.size() > 0) ? 1 : 0);
                if (q.size() > 0) begin
                    check("rnd out_vec",  o_vec[i],  q[0].vec);
                    check("rnd out_code", o_code[i], 128'(q[0].code));
                end
                check("rnd xfer_cnt", o_cnt[i], cnt_exp[i]);
                check("rnd err_oor",  o_err[i], err_exp[i]);
                ix  = d_valid[i] && o_irdy[i];
                ox  = o_ovld[i] && d_ordy[i];
                bad = (int'(d_code[i]) >= out_w_of(i)) || (d_mode[i] == 2'd3);
                @(posedge clk);
                if (ox && q.size() > 0) begin
                    void'(q.pop_front());
                    cnt_exp[i] = (cnt_exp[i] + 1) % cnt_mod_of(i);
                end
                if (ix) begin
                    e.vec  = ref_vec(int'(d_code[i]), int'(d_mode[i]), out_w_of(i));
                    e.code = d_code[i];
                    q.push_back(e);
                end
                if (ERR_EN) begin
                    if (ix && bad) err_exp[i] = 1'b1;
                    else if (d_clr[i]) err_exp[i] = 1'b0;
                end
                #1;
            end
            $display("random: instance %0d, 600 cycles, %0d transfers counted", i, cnt_exp[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_onehot_pipe.md
# decoder_onehot_pipe

Parametrised, pipelined binary-to-vector decoder with a valid/ready handshake on both sides. It generalises the fixed 6-to-64 combinational decoder to arbitrary input width and output count, and adds runtime-selectable decode modes, a registered output with a skid buffer, and a transfer counter. It sits between a code producer (address/select generator) and any consumer of one-hot or thermometer select vectors.

## Interface
- `IN_W`, default 6: code width; legal range 1..10.
- `OUT_W`, default 64: output vector width; must satisfy 2 ≤ OUT_W ≤ 2^IN_W.
- `CNT_W`, default 16: width of the transfer counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input code valid.
- `in_ready` out 1: block can accept a code.
- `in_code` in IN_W: binary code to decode.
- `in_mode` in 2: decode mode, sampled with `in_code`.
- `out_valid` out 1: `out_vec`/`out_code` valid.
- `out_ready` in 1: consumer accepts output.
- `out_vec` out OUT_W: decoded vector; bit k corresponds to code k, LSB = code 0.
- `out_code` out IN_W: echo of the accepted code.
- `xfer_cnt` out CNT_W: count of completed output transfers.
- `err_clr` in 1: clears `err_oor`.
- `err_oor` out 1: sticky out-of-range flag (see Configuration).

## Operation
- **Input transfer:** `in_valid & in_ready` at a rising edge. **Output transfer:** `out_valid & out_ready` at a rising edge.
- **Modes** (code c, c < OUT_W):
  - 00, one-hot: only bit c set.
  - 01, thermometer: bits 0..c set.
  - 10, inverted one-hot: all bits set except bit c.
  - 11, reserved: all zeros.
- **Out-of-range** (c ≥ OUT_W): all zeros in modes 00/01/11; all ones in mode 10. The transfer still completes normally.
- **Buffering:** two-entry buffer, consisting of the output register plus one skid register.
  - States: EMPTY, ONE, FULL.
  - EMPTY → ONE on an input transfer.
  - ONE → FULL on an input transfer without an output transfer.
  - ONE → EMPTY on an output transfer without an input transfer.
  - ONE stays ONE when both transfers occur.
  - FULL → ONE on an output transfer; the skid entry moves to the output register.
  - No input is accepted in FULL.
- `in_ready` is registered and equals "state != FULL" for the next cycle. There is no combinational path from `out_ready` to `in_ready`.
- Order is strictly FIFO; no entry is dropped or duplicated.
- `out_vec`/`out_code` hold stable while `out_valid=1` and `out_ready=0`.
- `xfer_cnt` increments by 1 on each output transfer and wraps from 2^CNT_W−1 to 0.

## Timing
- Latency: an input transfer at edge N gives `out_valid=1` after edge N (visible in cycle N+1).
- Throughput: 1 code per cycle when `out_ready` is held at 1.
- Values after reset:
  - `in_ready`=1, `out_valid`=0.
  - `out_vec`=0, `out_code`=0.
  - `xfer_cnt`=0, `err_oor`=0.
  - State EMPTY.
- Reset asserted mid-operation discards all buffered entries immediately (asynchronous). No output transfer is counted.
- `err_clr` and a new error in the same cycle: the set wins, so `err_oor`=1.

## Configuration
- **`DEC_OOR_ERR_EN` defined:**
  - `err_oor` is set on the cycle after any input transfer with `in_code` ≥ OUT_W or `in_mode`=11.
  - It stays set until `err_clr` is sampled high.
- **Not defined:**
  - `err_oor` is tied to 0 and `err_clr` is ignored.
  - Ports remain present.
  - Decode behaviour is identical in both builds.

## Structure
- **Package `dec_pkg`:**
  - Mode constants `DEC_ONEHOT`, `DEC_THERM`, `DEC_ONEHOT_N`, `DEC_RSVD`.
  - Buffer-state encoding `ST_EMPTY`/`ST_ONE`/`ST_FULL`.
  - A pure decode function taking (code, mode, OUT_W).
- **Sub-module `dec_skid_buf`:** the generic 2-entry valid/ready skid buffer, parametrised on payload width (OUT_W+IN_W).
  - Decode is combinational ahead of it.
  - Counter and error logic live in the top level.

## Test plan
- **Reset, then single transfer:** IN_W=6/OUT_W=64, mode 00, code 5, `out_ready`=1 → `out_vec`=0x20 one cycle later, `out_code`=5, `xfer_cnt`=1.
- **Mode sweep on code 3 (OUT_W=8):**
  - mode 01 → 0x0F.
  - mode 10 → 0xF7.
  - mode 11 → 0x00.
- **Backpressure:** `out_ready`=0 while codes 1, 2, 3 are offered.
  - Codes 1 and 2 are accepted; `in_ready`=0 afterwards, and code 3 is held by the producer.
  - Release `out_ready` → outputs in order 0x02, 0x04, 0x08 with no gaps; `xfer_cnt`=3.
- **Out-of-range (IN_W=4, OUT_W=10):**
  - Code 12, mode 00 → `out_vec`=0.
  - Code 12, mode 10 → `out_vec`=0x3FF.
  - With `DEC_OOR_ERR_EN` → `err_oor`=1 and held until `err_clr`. Simultaneous `err_clr` and a new error → stays 1.
- **Counter wrap:** CNT_W=4, 17 back-to-back transfers → `xfer_cnt`=1.
- **Reset mid-stream:** assert `rst_n`=0 in state FULL → `out_valid`=0 and `in_ready`=1 immediately after release. No stale data appears afterwards.
